// File: rtl/axi_stream_burst_writer_pkg.sv
// Shared types and AXI constants for the stream-to-AXI4 burst writer.
package axi_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/axi_stream_burst_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst writer and a memory responder.
interface axi_stream_burst_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
) ();
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_stream_burst_writer_len_calc.sv
// Combinational burst length: min(remaining beats, MAX_BURST_LEN, beats left before the 4 KB page end).
module axi_burst_len_calc
    import axi_writer_pkg::*;
#(
    parameter int STRB_WIDTH    = 4,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [15:0] remaining,
    input  logic [11:0] addr_lo,
    output logic [8:0]  len
);
    localparam int SHIFT = $clog2(STRB_WIDTH);

    logic [12:0] bytes_to_4k;
    logic [12:0] beats_to_4k;
    logic [16:0] cand;

    // NOTE: every variable in this block is assigned before any branch reads or updates it, so no latch can be inferred.
    always_comb begin
        bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
        beats_to_4k = bytes_to_4k >> SHIFT;
        cand        = {1'b0, remaining};
        if (17'(MAX_BURST_LEN) < cand) cand = 17'(MAX_BURST_LEN);
        if ({4'b0, beats_to_4k} < cand) cand = {4'b0, beats_to_4k};
        len = 9'(cand);
    end

endmodule

// File: rtl/axi_stream_burst_writer.sv
// Stream-fed AXI4 write master: one command becomes a sequence of 4 KB-safe INCR bursts.
// Optional build macro WR_ERR_ABORT_EN: stop issuing bursts after the first non-OKAY response.
module axi_stream_burst_writer
    import axi_writer_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int AXI_ID        = 0,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_beats,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    axi_stream_burst_writer_if.master m_axi
);
    localparam int SHIFT = $clog2(STRB_WIDTH);

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [8:0]            len_q, len_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_sticky_q, err_sticky_d;
    logic                  awvalid_q, awvalid_d;

    logic       run;
    logic       w_fire;
    logic       last_beat;
    logic       abort;
    logic [8:0] calc_len;
    logic       unused_bid;

    // Outputs are forced quiet while rst is high so no handshake can complete in the reset cycle.
    assign run       = !rst;
    assign last_beat = (beat_cnt_q == 8'(len_q - 9'd1));
    assign w_fire    = m_axi.wvalid && m_axi.wready;

    assign cmd_ready = run && (state_q == ST_IDLE);
    assign busy      = run && (state_q != ST_IDLE);
    assign done      = run && (state_q == ST_DONE);
    assign err       = done && err_sticky_q;
    assign s_ready   = run && (state_q == ST_W) && m_axi.wready;

    assign m_axi.awid    = ID_WIDTH'(AXI_ID);
    assign m_axi.awsize  = 3'(SHIFT);
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awvalid = run && awvalid_q;
    assign m_axi.awaddr  = run ? addr_q : '0;
    assign m_axi.awlen   = m_axi.awvalid ? 8'(len_q - 9'd1) : 8'd0;
    assign m_axi.wdata   = s_data;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = run && (state_q == ST_W) && s_valid;
    assign m_axi.wlast   = run && (state_q == ST_W) && last_beat;
    assign m_axi.bready  = run && (state_q == ST_B);
    assign unused_bid    = ^m_axi.bid;

    // Length is computed from the next-state address/count so it is ready the cycle AW opens.
    axi_burst_len_calc #(
        .STRB_WIDTH    (STRB_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_len_calc (
        .remaining (remaining_d),
        .addr_lo   (addr_d[11:0]),
        .len       (calc_len)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        err_sticky_d = err_sticky_q;
        abort        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d       = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
                    remaining_d  = cmd_beats;
                    err_sticky_d = 1'b0;
                    state_d      = (cmd_beats == 16'd0) ? ST_DONE : ST_AW;
                end
            end
            ST_AW: begin
                if (m_axi.awvalid && m_axi.awready) begin
                    beat_cnt_d = 8'd0;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                if (w_fire) begin
                    if (last_beat) begin
                        beat_cnt_d = 8'd0;
                        state_d    = ST_B;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            ST_B: begin
                if (m_axi.bvalid) begin
                    err_sticky_d = err_sticky_q | (m_axi.bresp != AXI_RESP_OKAY);
                    remaining_d  = remaining_q - 16'(len_q);
                    addr_d       = addr_q + (ADDR_WIDTH'(len_q) << SHIFT);
`ifdef WR_ERR_ABORT_EN
                    abort        = (m_axi.bresp != AXI_RESP_OKAY);
`else
                    abort        = 1'b0;
`endif
                    state_d      = (remaining_d == 16'd0 || abort) ? ST_DONE : ST_AW;
                end
            end
            ST_DONE: begin
                err_sticky_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_AW && state_q != ST_AW) len_d = calc_len;
    end

    assign awvalid_d = (state_d == ST_AW);

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            err_sticky_q <= 1'b0;
            awvalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            err_sticky_q <= err_sticky_d;
            awvalid_q    <= awvalid_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_burst_writer.sv
// Directed bench for axi_stream_burst_writer: burst splitting, backpressure, errors, reset.
module tb_axi_stream_burst_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [15:0] got_aw_addr[$];
    logic [7:0]  got_aw_len[$];
    logic [15:0] exp_aw_addr[$];
    logic [7:0]  exp_aw_len[$];
    logic [1:0]  resp_tab[$];

    logic [15:0] lc_remaining;
    logic [11:0] lc_addr_lo;
    logic [8:0]  lc_len;

    always #5 clk = ~clk;

    axi_stream_burst_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) m_axi ();

    axi_stream_burst_writer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4),
        .ID_WIDTH(8), .AXI_ID(0), .MAX_BURST_LEN(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_beats (cmd_beats),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .m_axi     (m_axi.master)
    );

    axi_burst_len_calc #(.STRB_WIDTH(4), .MAX_BURST_LEN(16)) u_lc (
        .remaining (lc_remaining),
        .addr_lo   (lc_addr_lo),
        .len       (lc_len)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid      = 1'b0;
        s_valid        = 1'b0;
        m_axi.awready  = 1'b0;
        m_axi.wready   = 1'b0;
        m_axi.bvalid   = 1'b0;
        m_axi.bresp    = 2'b00;
        m_axi.bid      = 8'h00;
    endtask

    task automatic lc_vec(input string tag, input logic [15:0] rem, input logic [11:0] a, input logic [8:0] exp);
        lc_remaining = rem;
        lc_addr_lo   = a;
        #1;
        check(tag, 32'(lc_len), 32'(exp));
    endtask

    // Drives one command, plays the AXI slave and the payload source, and checks the whole transaction.
    task automatic run_cmd(input string name, input logic [15:0] addr, input logic [15:0] beats,
                           input bit bp, input int exp_aws, input int exp_beats, input logic exp_err);
        int idx = 0;
        int beat_in = 0;
        int cur_len = 0;
        int pending = 0;
        int b_idx = 0;
        int acc_cyc;
        int b_cyc = -1;
        int done_cyc = -1;
        bit stall = 1'b0;
        logic [15:0] st_addr = '0;
        logic [7:0]  st_len = '0;
        got_aw_addr.delete();
        got_aw_len.delete();

        @(negedge clk);
        cyc++;
        idle_inputs();
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_beats = beats;
        #1;
        check({name, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        acc_cyc = cyc;

        for (int t = 0; t < 3000 && done_cyc < 0; t++) begin
            @(negedge clk);
            cyc++;
            cmd_valid     = 1'b0;
            m_axi.awready = bp ? ($urandom % 3 != 0) : 1'b1;
            m_axi.wready  = bp ? ($urandom % 3 != 0) : 1'b1;
            s_valid       = bp ? ($urandom % 4 != 0) : 1'b1;
            s_data        = 32'hA000_0000 + 32'(idx);
            m_axi.bvalid  = (pending > 0);
            m_axi.bresp   = (b_idx < resp_tab.size()) ? resp_tab[b_idx] : 2'b00;
            #1;
            if (stall) begin
                check({name, ".aw_hold_valid"}, 32'(m_axi.awvalid), 32'd1);
                check({name, ".aw_hold_addr"}, 32'(m_axi.awaddr), 32'(st_addr));
                check({name, ".aw_hold_len"}, 32'(m_axi.awlen), 32'(st_len));
            end
            stall   = m_axi.awvalid && !m_axi.awready;
            st_addr = m_axi.awaddr;
            st_len  = m_axi.awlen;
            if (m_axi.awvalid && m_axi.awready) begin
                got_aw_addr.push_back(m_axi.awaddr);
                got_aw_len.push_back(m_axi.awlen);
                cur_len = int'(m_axi.awlen);
            end
            if (m_axi.wvalid && m_axi.wready) begin
                check({name, ".wdata"}, m_axi.wdata, 32'hA000_0000 + 32'(idx));
                check({name, ".wlast"}, 32'(m_axi.wlast), 32'(beat_in == cur_len));
                idx++;
                if (beat_in == cur_len) begin
                    beat_in = 0;
                    pending++;
                end else begin
                    beat_in++;
                end
            end
            if (m_axi.bvalid && m_axi.bready) begin
                pending--;
                b_idx++;
                b_cyc = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                check({name, ".err"}, 32'(err), 32'(exp_err));
                check({name, ".busy_in_done"}, 32'(busy), 32'd1);
            end
        end

        if (done_cyc < 0) begin
            check({name, ".timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, ".aw_count"}, got_aw_addr.size(), exp_aws);
            check({name, ".beats"}, idx, exp_beats);
            for (int i = 0; i < got_aw_addr.size() && i < exp_aw_addr.size() && i < exp_aws; i++) begin
                check($sformatf("%s.awaddr%0d", name, i), 32'(got_aw_addr[i]), 32'(exp_aw_addr[i]));
                check($sformatf("%s.awlen%0d", name, i), 32'(got_aw_len[i]), 32'(exp_aw_len[i]));
            end
            if (beats == 16'd0) check({name, ".done_lat"}, done_cyc - acc_cyc, 1);
            else                check({name, ".done_lat"}, done_cyc - b_cyc, 1);
            @(negedge clk);
            cyc++;
            idle_inputs();
            #1;
            check({name, ".done_pulse"}, 32'(done), 32'd0);
            check({name, ".busy_after"}, 32'(busy), 32'd0);
            check({name, ".ready_after"}, 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        cmd_addr  = '0;
        cmd_beats = '0;
        s_data    = '0;
        idle_inputs();

        lc_vec("lc.remaining", 16'd3,   12'h000, 9'd3);
        lc_vec("lc.max",       16'd100, 12'h000, 9'd16);
        lc_vec("lc.4k_one",    16'd100, 12'hFFC, 9'd1);
        lc_vec("lc.4k_eight",  16'd10,  12'hFE0, 9'd8);
        lc_vec("lc.4k_exact",  16'd100, 12'hFC0, 9'd16);

        repeat (2) @(negedge clk);
        #1;
        check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst.busy",      32'(busy), 32'd0);
        check("rst.done",      32'(done), 32'd0);
        check("rst.awvalid",   32'(m_axi.awvalid), 32'd0);
        check("rst.wvalid",    32'(m_axi.wvalid), 32'd0);
        check("rst.bready",    32'(m_axi.bready), 32'd0);
        check("rst.awsize",    32'(m_axi.awsize), 32'd2);
        check("rst.awburst",   32'(m_axi.awburst), 32'd1);
        check("rst.wstrb",     32'(m_axi.wstrb), 32'hF);
        check("rst.awid",      32'(m_axi.awid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        exp_aw_addr = '{16'h0000};
        exp_aw_len  = '{8'd3};
        resp_tab    = '{2'b00};
        run_cmd("single", 16'h0000, 16'd4, 1'b0, 1, 4, 1'b0);

        exp_aw_addr = '{16'h0000, 16'h0040, 16'h0080};
        exp_aw_len  = '{8'd15, 8'd15, 8'd7};
        resp_tab    = '{2'b00, 2'b00, 2'b00};
        run_cmd("split40", 16'h0000, 16'd40, 1'b0, 3, 40, 1'b0);

        exp_aw_addr = '{16'h0FF8, 16'h1000};
        exp_aw_len  = '{8'd1, 8'd1};
        run_cmd("cross4k", 16'h0FF8, 16'd4, 1'b0, 2, 4, 1'b0);

        exp_aw_addr.delete();
        exp_aw_len.delete();
        run_cmd("zero", 16'h0100, 16'd0, 1'b0, 0, 0, 1'b0);

        exp_aw_addr = '{16'h0200};
        exp_aw_len  = '{8'd0};
        run_cmd("unaligned", 16'h0203, 16'd1, 1'b0, 1, 1, 1'b0);

        exp_aw_addr = '{16'h0100, 16'h0140};
        exp_aw_len  = '{8'd15, 8'd3};
        run_cmd("backpressure", 16'h0100, 16'd20, 1'b1, 2, 20, 1'b0);

        exp_aw_addr = '{16'h0000, 16'h0040, 16'h0080};
        exp_aw_len  = '{8'd15, 8'd15, 8'd7};
        resp_tab    = '{2'b10, 2'b00, 2'b00};
`ifdef WR_ERR_ABORT_EN
        run_cmd("slverr", 16'h0000, 16'd40, 1'b0, 1, 16, 1'b1);
`else
        run_cmd("slverr", 16'h0000, 16'd40, 1'b0, 3, 40, 1'b1);
`endif
        resp_tab = '{2'b00, 2'b00};

        // Reset in the middle of the data phase of a 20-beat command.
        @(negedge clk);
        idle_inputs();
        cmd_valid = 1'b1;
        cmd_addr  = 16'h0000;
        cmd_beats = 16'd20;
        n = 0;
        for (int t = 0; t < 50 && n < 3; t++) begin
            @(negedge clk);
            cmd_valid     = 1'b0;
            m_axi.awready = 1'b1;
            m_axi.wready  = 1'b1;
            s_valid       = 1'b1;
            s_data        = 32'hB000_0000 + 32'(n);
            #1;
            if (m_axi.wvalid && m_axi.wready) n++;
        end
        check("midrst.reach_w", n, 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.wvalid_in_rst", 32'(m_axi.wvalid), 32'd0);
        check("midrst.s_ready_in_rst", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst.wvalid", 32'(m_axi.wvalid), 32'd0);
        check("midrst.awvalid", 32'(m_axi.awvalid), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);

        exp_aw_addr = '{16'h0000};
        exp_aw_len  = '{8'd3};
        run_cmd("after_rst", 16'h0000, 16'd4, 1'b0, 1, 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
